// File: rtl/scroll_pkg.sv
// Shared state codes, message-length table and blank index for the scroller.
// Optional auto-advance of the message index is enabled with SCROLL_AUTO_NEXT_EN.
package scroll_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam logic [4:0] BLANK_IDX = 5'd31;
  localparam int         PW        = 25;

  // entry n is the length of message n
  localparam logic [7:0][4:0] MSG_LEN = {
    5'd11, 5'd11, 5'd11, 5'd13,
    5'd11, 5'd10, 5'd17, 5'd11
  };

  function automatic logic [4:0] msg_last(
    input logic [2:0] n
  );
    return MSG_LEN[n] - 5'd1;
  endfunction

endpackage

// File: rtl/scroll_tick.sv
// Step prescaler: counts to period-1, pulses tick and restarts.
// Uses >= so a shortened period fires on the next compare.
module scroll_tick #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q >= (period - W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Character-index sequencer for a scrolling seg7 message display.
// Define SCROLL_AUTO_NEXT_EN to advance to the next message on every wrap.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic [2:0] name_sel,
  input  logic [1:0] speed,
  output logic [4:0] counter,
  output logic [2:0] name,
  output logic       busy,
  output logic       wrap
);

  localparam logic [PW-1:0] DIV = PW'(TICK_DIV);

  state_t       st_q, st_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [2:0]   name_q, name_d;
  logic         wrap_q, wrap_d;
  logic         run_en;
  logic         clr;
  logic         tick;
  logic [PW-1:0] period;

  assign busy    = (st_q != ST_IDLE);
  assign counter = cnt_q;
  assign name    = name_q;
  assign wrap    = wrap_q & ena;
  assign period  = DIV >> speed;

  // counting only when nothing of higher priority is pending
  assign run_en = ena & busy & ~start & ~stop & ~hold;
  assign clr    = ena & (start | stop);

  scroll_tick #(
    .W(PW)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .en     (run_en),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    name_d = name_q;
    wrap_d = 1'b0;
    if (ena) begin
      if (start) begin
        st_d   = ST_RUN;
        cnt_d  = 5'd0;
        name_d = name_sel;
      end else if (stop) begin
        if (busy) begin
          st_d  = ST_IDLE;
          cnt_d = BLANK_IDX;
        end
      end else if (busy) begin
        if (hold) begin
          st_d = ST_PAUSE;
        end else begin
          st_d = ST_RUN;
          if (tick) begin
            if (cnt_q == msg_last(name_q)) begin
              cnt_d  = 5'd0;
              wrap_d = 1'b1;
`ifdef SCROLL_AUTO_NEXT_EN
              name_d = name_q + 3'd1;
`else
              name_d = name_q;
`endif
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= BLANK_IDX;
      name_q <= 3'd0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      name_q <= name_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Scoreboard bench for scroll_ctrl: expected counter changes are queued
// with their due cycle when stimulus is driven and checked as they appear.
module tb_scroll_ctrl;

  typedef struct {
    int cyc;
    int cnt;
    int nm;
    int wr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop, hold;
  logic [2:0] name_sel;
  logic [1:0] speed;
  logic [4:0] cnt_a, cnt_b;
  logic [2:0] name_a, name_b;
  logic       busy_a, busy_b, wrap_a, wrap_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_a = 0;
  bit   mon_b = 0;
  int   pa = -1;
  int   pb = -1;
  ev_t  qa[$];
  ev_t  qb[$];
  ev_t  ea, eb;
  int   c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scroll_ctrl #(.TICK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .hold(hold), .name_sel(name_sel), .speed(speed),
    .counter(cnt_a), .name(name_a), .busy(busy_a), .wrap(wrap_a)
  );

  scroll_ctrl #(.TICK_DIV(8)) u_b (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop),
    .hold(hold), .name_sel(name_sel), .speed(speed),
    .counter(cnt_b), .name(name_b), .busy(busy_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int nx(input int n);
`ifdef SCROLL_AUTO_NEXT_EN
    return (n + 1) % 8;
`else
    return n;
`endif
  endfunction

  task automatic sched(input bit b, input int cy, input int cn,
                       input int nm, input int wr);
    ev_t e;
    e.cyc = cy; e.cnt = cn; e.nm = nm; e.wr = wr;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_a) begin
      if (int'(cnt_a) != pa) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_step", int'(cnt_a), pa);
        end else begin
          ea = qa.pop_front();
          chk("a_counter", int'(cnt_a), ea.cnt);
          chk("a_cycle", cyc, ea.cyc);
          chk("a_name", int'(name_a), ea.nm);
          chk("a_wrap", int'(wrap_a), ea.wr);
        end
      end else if (wrap_a) begin
        chk("a_spurious_wrap", 1, 0);
      end
    end
    pa = int'(cnt_a);
  end

  always @(negedge clk) begin
    if (mon_b) begin
      if (int'(cnt_b) != pb) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_step", int'(cnt_b), pb);
        end else begin
          eb = qb.pop_front();
          chk("b_counter", int'(cnt_b), eb.cnt);
          chk("b_cycle", cyc, eb.cyc);
          chk("b_name", int'(name_b), eb.nm);
          chk("b_wrap", int'(wrap_b), eb.wr);
        end
      end else if (wrap_b) begin
        chk("b_spurious_wrap", 1, 0);
      end
    end
    pb = int'(cnt_b);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; ena = 1; start = 0; stop = 0; hold = 0;
    name_sel = 0; speed = 0;
    repeat (3) @(negedge clk);
    chk("rst_counter", int'(cnt_a), 31);
    chk("rst_name", int'(name_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_wrap", int'(wrap_a), 0);
    rst = 0;
    @(negedge clk);
    mon_a = 1;

    // name 2, 4-cycle steps, wrap, hold, then reset at counter 7
    c = cyc; name_sel = 3'd2; start = 1;
    sched(0, c + 1, 0, 2, 0);
    for (int k = 1; k <= 9; k++) sched(0, c + 1 + 4 * k, k, 2, 0);
    sched(0, c + 41, 0, nx(2), 1);
    sched(0, c + 45, 1, nx(2), 0);
    sched(0, c + 49, 2, nx(2), 0);
    @(negedge clk); start = 0;
    wait_cyc(c + 50); hold = 1;
    wait_cyc(c + 70);
    chk("hold_counter", int'(cnt_a), 2);
    chk("hold_busy", int'(busy_a), 1);
    hold = 0;
    sched(0, c + 73, 3, nx(2), 0);
    for (int k = 4; k <= 7; k++) sched(0, c + 73 + 4 * (k - 3), k, nx(2), 0);
    wait_cyc(c + 89);
    chk("pre_rst_counter", int'(cnt_a), 7);
    rst = 1;
    sched(0, c + 90, 31, 0, 0);
    @(negedge clk); rst = 0;
    chk("midrun_rst_busy", int'(busy_a), 0);
    chk("midrun_rst_name", int'(name_a), 0);

    // start and stop together from IDLE, then stop, then stop in IDLE
    c = cyc; name_sel = 3'd5; start = 1; stop = 1;
    sched(0, c + 1, 0, 5, 0);
    @(negedge clk); start = 0; stop = 0;
    chk("startstop_busy", int'(busy_a), 1);
    stop = 1;
    sched(0, c + 2, 31, 5, 0);
    @(negedge clk); stop = 0;
    chk("stop_busy", int'(busy_a), 0);
    stop = 1;
    @(negedge clk); stop = 0;
    @(negedge clk);
    chk("idle_stop_busy", int'(busy_a), 0);
    chk("idle_stop_counter", int'(cnt_a), 31);

    // ena low freezes everything and drops pulses
    c = cyc; name_sel = 3'd0; start = 1;
    sched(0, c + 1, 0, 0, 0);
    sched(0, c + 5, 1, 0, 0);
    @(negedge clk); start = 0;
    wait_cyc(c + 6); ena = 0;
    repeat (4) @(negedge clk);
    stop = 1;
    @(negedge clk); stop = 0;
    wait_cyc(c + 16);
    chk("ena_busy", int'(busy_a), 1);
    chk("ena_counter", int'(cnt_a), 1);
    ena = 1;
    sched(0, c + 19, 2, 0, 0);
    wait_cyc(c + 20); stop = 1;
    sched(0, c + 21, 31, 0, 0);
    @(negedge clk); stop = 0;
    repeat (2) @(negedge clk);

    // TICK_DIV=8 at speed 2: 2-cycle steps, message 1 wraps after 17
    mon_a = 0; mon_b = 1; speed = 2'd2;
    c = cyc; name_sel = 3'd1; start = 1;
    sched(1, c + 1, 0, 1, 0);
    for (int k = 1; k <= 16; k++) sched(1, c + 1 + 2 * k, k, 1, 0);
    sched(1, c + 35, 0, nx(1), 1);
    @(negedge clk); start = 0;
    wait_cyc(c + 36); stop = 1;
    sched(1, c + 37, 31, nx(1), 0);
    @(negedge clk); stop = 0;
    repeat (2) @(negedge clk);
    mon_b = 0; speed = 2'd0;
    @(negedge clk);
    mon_a = 1;

    // speed raised with prescaler already past the new terminal count
    c = cyc; name_sel = 3'd3; start = 1;
    sched(0, c + 1, 0, 3, 0);
    @(negedge clk); start = 0;
    wait_cyc(c + 3); speed = 2'd1;
    sched(0, c + 4, 1, 3, 0);
    sched(0, c + 6, 2, 3, 0);
    wait_cyc(c + 6); stop = 1;
    sched(0, c + 7, 31, 3, 0);
    @(negedge clk); stop = 0; speed = 2'd0;
    repeat (2) @(negedge clk);

    // message 7 wraps: name advances only with auto-next enabled
    c = cyc; name_sel = 3'd7; start = 1;
    sched(0, c + 1, 0, 7, 0);
    for (int k = 1; k <= 10; k++) sched(0, c + 1 + 4 * k, k, 7, 0);
    sched(0, c + 45, 0, nx(7), 1);
    @(negedge clk); start = 0;
    wait_cyc(c + 45); stop = 1;
    sched(0, c + 46, 31, nx(7), 0);
    @(negedge clk); stop = 0;
    repeat (3) @(negedge clk);

    chk("a_events_left", qa.size(), 0);
    chk("b_events_left", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, base clock cycles per character step at speed 0 (legal range 4..2^24).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ena  input  1  global enable; while low, all state freezes.
REQ-005 SHALL have port start  input  1  one-cycle pulse; loads name_sel and begins scrolling from character 0.
REQ-006 SHALL have port stop  input  1  one-cycle pulse; returns to IDLE.
REQ-007 SHALL have port hold  input  1  level; freezes scrolling while high.
REQ-008 SHALL have port name_sel  input  3  message index, sampled only on start.
REQ-009 SHALL have port speed  input  2  step period = TICK_DIV >> speed cycles.
REQ-010 SHALL have port counter  output  5  character index driven to the seg7 decoder.
REQ-011 SHALL have port name  output  3  message index driven to the seg7 decoder.
REQ-012 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when counter wraps to 0.

Function
REQ-014 SHALL implement states IDLE, RUN and PAUSE.
REQ-015 IDLE SHALL drive counter=31, which is blank for every message.
REQ-016 start in any state SHALL latch name_sel into name, set counter=0, clear the prescaler and enter RUN on the next cycle.
REQ-017 In RUN, the prescaler SHALL count 0..(TICK_DIV>>speed)-1; at the terminal count it SHALL clear and advance counter by 1.
REQ-018 Message lengths SHALL be, for names 0..7: 11, 17, 10, 11, 13, 11, 11, 11.
REQ-019 A step from counter=LEN(name)-1 SHALL set counter=0 and assert wrap for exactly that cycle.
REQ-020 RUN with hold=1 SHALL go to PAUSE; PAUSE with hold=0 SHALL return to RUN.
REQ-021 In PAUSE, the prescaler and counter SHALL be held unchanged.
REQ-022 stop SHALL enter IDLE next cycle and clear the prescaler; stop in IDLE SHALL have no effect.
REQ-023 Simultaneous events SHALL resolve with priority rst > start > stop > hold > tick.
REQ-024 A speed change mid-step SHALL take effect at the next compare; if the prescaler is already at or above the new terminal count, the step SHALL occur on that cycle.
REQ-025 ena=0 SHALL freeze state, prescaler and counter, and SHALL force wrap low; pulses arriving while ena=0 SHALL be ignored.
REQ-026 counter and name SHALL be registered outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL enter IDLE with counter=31, name=0, busy=0, wrap=0 and prescaler=0.
REQ-028 Reset mid-RUN SHALL take effect on the same edge and override every other input.

Configuration
REQ-029 With SCROLL_AUTO_NEXT_EN defined, each wrap SHALL increment name modulo 8 (7 -> 0) and restart from counter 0.
REQ-030 Without SCROLL_AUTO_NEXT_EN, name SHALL stay constant until the next start.

Structure
REQ-031 A shared package scroll_pkg SHALL hold the state enum, the 8-entry length table, and BLANK_IDX=31.
REQ-032 The prescaler SHALL be a sub-module, scroll_tick, with inputs clr, en and period and output tick.
REQ-033 The seg7 decoder SHALL be instantiated by the parent, not by scroll_ctrl.

Verification
REQ-034 Bench: TICK_DIV=4, speed=0, start with name_sel=2 -> counter 0..9 stepping every 4 cycles; wrap pulses on the 9->0 step.
REQ-035 Bench: after 2 steps, hold=1 for 20 cycles -> counter stays 2 and busy=1; hold=0 -> step 3 arrives 4 cycles later minus elapsed prescaler.
REQ-036 Bench: start and stop in the same cycle while IDLE -> RUN, counter=0, name latched.
REQ-037 Bench: rst asserted at counter=7 in RUN -> next cycle counter=31, busy=0, name=0.
REQ-038 Bench: speed=2, TICK_DIV=8 -> step every 2 cycles; name_sel=1 wraps after 17 steps.
REQ-039 Bench with SCROLL_AUTO_NEXT_EN: start with name_sel=7, let it wrap -> name becomes 0 and counter becomes 0; without the macro, name stays 7.
